// File: rtl/score_controller_if.sv
// rtl/score_controller_if.sv - match control inputs and score/serve outputs of the Pong score controller
interface score_controller_if;
  logic       start;
  logic       goal_first;
  logic       goal_second;
  logic [6:0] points_first_player;
  logic [6:0] points_second_player;
  logic       ball_enable;
  logic       serve_req;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, goal_first, goal_second,
    input  points_first_player, points_second_player, ball_enable, serve_req, game_over, winner
  );

  modport slave (
    input  start, goal_first, goal_second,
    output points_first_player, points_second_player, ball_enable, serve_req, game_over, winner
  );
endinterface

// File: rtl/score_controller.sv
// rtl/score_controller.sv - Pong match sequencer: scores, serve pause, win detection
// Optional SCORE_BLINK_EN: blinks the winner's score in game-over.
module score_controller #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 65_000_000,
  parameter int BLINK_CYCLES = 16_250_000
) (
  input logic              clk,
  input logic              rst,
  score_controller_if.slave bus
);
  localparam int CW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_CYCLES - 1);
  localparam logic [6:0] WIN = 7'(WIN_SCORE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PAUSE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  generate
    if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win
      $error("WIN_SCORE must be in 1..9");
    end
    if (PAUSE_CYCLES < 1) begin : g_bad_pause
      $error("PAUSE_CYCLES must be at least 1");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
      $error("BLINK_CYCLES must be at least 1");
    end
  endgenerate

  logic [1:0]    state;
  logic [CW-1:0] pause_cnt;
  logic [6:0]    score_first;
  logic [6:0]    score_second;
  logic          ball_en_q;
  logic          serve_q;
  logic          over_q;
  logic [1:0]    winner_q;
  logic [6:0]    first_inc;
  logic [6:0]    second_inc;

  assign first_inc  = score_first + 7'd1;
  assign second_inc = score_second + 7'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pause_cnt    <= '0;
      score_first  <= '0;
      score_second <= '0;
      ball_en_q    <= 1'b0;
      serve_q      <= 1'b0;
      over_q       <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      serve_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state        <= S_PAUSE;
            pause_cnt    <= '0;
            score_first  <= '0;
            score_second <= '0;
          end
        end
        S_PAUSE: begin
          if (pause_cnt == PAUSE_LAST) begin
            pause_cnt <= '0;
            serve_q   <= 1'b1;
            ball_en_q <= 1'b1;
            state     <= S_PLAY;
          end else begin
            pause_cnt <= pause_cnt + CW'(1);
          end
        end
        S_PLAY: begin
          // goal_first has priority; a simultaneous goal_second is dropped
          if (bus.goal_first) begin
            score_first <= first_inc;
            ball_en_q   <= 1'b0;
            if (first_inc == WIN) begin
              state    <= S_OVER;
              over_q   <= 1'b1;
              winner_q <= 2'b01;
            end else begin
              state     <= S_PAUSE;
              pause_cnt <= '0;
            end
          end else if (bus.goal_second) begin
            score_second <= second_inc;
            ball_en_q    <= 1'b0;
            if (second_inc == WIN) begin
              state    <= S_OVER;
              over_q   <= 1'b1;
              winner_q <= 2'b10;
            end else begin
              state     <= S_PAUSE;
              pause_cnt <= '0;
            end
          end
        end
        S_OVER: begin
          if (bus.start) begin
            state        <= S_PAUSE;
            pause_cnt    <= '0;
            score_first  <= '0;
            score_second <= '0;
            winner_q     <= 2'b00;
            over_q       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_hidden;

  // held at zero outside game-over, so every game-over entry starts visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (state != S_OVER) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt    <= '0;
      blink_hidden <= ~blink_hidden;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign bus.points_first_player  = (over_q && blink_hidden && winner_q == 2'b01) ? 7'd127 : score_first;
  assign bus.points_second_player = (over_q && blink_hidden && winner_q == 2'b10) ? 7'd127 : score_second;
`else
  assign bus.points_first_player  = score_first;
  assign bus.points_second_player = score_second;
`endif

  assign bus.ball_enable = ball_en_q;
  assign bus.serve_req   = serve_q;
  assign bus.game_over   = over_q;
  assign bus.winner      = winner_q;
endmodule

// File: tb/tb_score_controller.sv
// tb/tb_score_controller.sv - directed and random checks of score_controller against a match-level model
module tb_score_controller;
  localparam int WIN   = 3;
  localparam int PAUSE = 4;
  localparam int BLINK = 2;

  localparam int M_IDLE  = 0;
  localparam int M_PAUSE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_OVER  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_controller_if bus ();

  score_controller #(
    .WIN_SCORE   (WIN),
    .PAUSE_CYCLES(PAUSE),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // match-level model: mode, cycles left in the pause, scores, winner, cycles spent in game-over
  int m_mode, m_left, m_s1, m_s2, m_win, m_age;
  bit m_serve;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_age = 0; m_serve = 0;
  endtask

  task automatic model_step(input bit st, input bit g1, input bit g2);
    m_serve = 0;
    case (m_mode)
      M_IDLE: if (st) begin
        m_mode = M_PAUSE; m_left = PAUSE; m_s1 = 0; m_s2 = 0;
      end
      M_PAUSE: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_PLAY; m_serve = 1;
        end
      end
      M_PLAY: begin
        if (g1) begin
          m_s1++;
          if (m_s1 == WIN) begin m_mode = M_OVER; m_win = 1; m_age = 0; end
          else begin m_mode = M_PAUSE; m_left = PAUSE; end
        end else if (g2) begin
          m_s2++;
          if (m_s2 == WIN) begin m_mode = M_OVER; m_win = 2; m_age = 0; end
          else begin m_mode = M_PAUSE; m_left = PAUSE; end
        end
      end
      default: begin
        if (st) begin
          m_mode = M_PAUSE; m_left = PAUSE; m_s1 = 0; m_s2 = 0; m_win = 0;
        end else begin
          m_age++;
        end
      end
    endcase
  endtask

  function automatic int exp_points(input int who, input int score);
    bit hidden;
    hidden = 0;
`ifdef SCORE_BLINK_EN
    hidden = (m_mode == M_OVER) && (m_win == who) && (((m_age / BLINK) % 2) == 1);
`endif
    return hidden ? 127 : score;
  endfunction

  task automatic check_all();
    chk("points_first",  {1'b0, bus.points_first_player},  8'(exp_points(1, m_s1)));
    chk("points_second", {1'b0, bus.points_second_player}, 8'(exp_points(2, m_s2)));
    chk("ball_enable",   {7'd0, bus.ball_enable}, 8'(m_mode == M_PLAY));
    chk("serve_req",     {7'd0, bus.serve_req},   8'(m_serve));
    chk("game_over",     {7'd0, bus.game_over},   8'(m_mode == M_OVER));
    chk("winner",        {6'd0, bus.winner},      8'(m_win));
  endtask

  task automatic cycle(input bit st, input bit g1, input bit g2);
    @(negedge clk);
    bus.start = st; bus.goal_first = g1; bus.goal_second = g2;
    @(posedge clk);
    model_step(st, g1, g2);
    #1;
    check_all();
  endtask

  task automatic wait_serve(input int exp_n);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      cycle(0, 0, 0);
      n++;
      if (bus.serve_req === 1'b1) seen = 1;
    end
    chk("serve_latency", 8'(seen ? n : 99), 8'(exp_n));
  endtask

  // rst raised between clock edges must clear outputs without waiting for clk
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    bus.start = 0; bus.goal_first = 0; bus.goal_second = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.goal_first = 0; bus.goal_second = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    cycle(0, 1, 0);
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    wait_serve(4);

    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 1);
    wait_serve(2);

    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    wait_serve(4);
    cycle(0, 0, 1);
    wait_serve(4);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);

    cycle(1, 0, 0);
    wait_serve(4);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    async_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);

    cycle(1, 0, 0);
    wait_serve(4);
    async_reset();

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
